// File: rtl/vga_sincronizador.sv
// 640x480@60 Hz VGA raster timing: pixel-strobe prescaler, horizontal/vertical
// phase FSMs and counters, with every output registered from next-state values.
module vga_sincronizador #(
  parameter int DIV    = 4,
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic       reloj,
  input  logic       reset,
  output logic [9:0] Qh,
  output logic [9:0] Qv,
  output logic       pixel_tick,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       fin_cuadro
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DW      = $clog2(DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [DW-1:0] DIV_ZERO = {DW{1'b0}};
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);

  localparam logic [9:0] H_VIS_END  = 10'(H_VIS - 1);
  localparam logic [9:0] H_FP_END   = 10'(H_VIS + H_FP - 1);
  localparam logic [9:0] H_SYNC_END = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] H_END      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_VIS_END  = 10'(V_VIS - 1);
  localparam logic [9:0] V_FP_END   = 10'(V_VIS + V_FP - 1);
  localparam logic [9:0] V_SYNC_END = 10'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [9:0] V_END      = 10'(V_TOTAL - 1);

  typedef enum logic [1:0] {
    H_VISIBLE = 2'd0,
    H_FRONT   = 2'd1,
    H_SYNCP   = 2'd2,
    H_BACK    = 2'd3
  } h_state_e;

  typedef enum logic [1:0] {
    V_VISIBLE = 2'd0,
    V_FRONT   = 2'd1,
    V_SYNCP   = 2'd2,
    V_BACK    = 2'd3
  } v_state_e;

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [9:0]    qh_q, qh_d, qv_q, qv_d;
  h_state_e      h_state_q, h_state_d;
  v_state_e      v_state_q, v_state_d;
  logic          pixel_tick_q, pixel_tick_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          video_on_q, video_on_d;
  logic          fin_cuadro_q, fin_cuadro_d;
  logic          tick_s, eol_s;

  // Prescaler and raster counters; Qv only moves on the end-of-line tick.
  always_comb begin
    tick_s    = (div_cnt_q == DIV_LAST);
    eol_s     = tick_s && (qh_q == H_END);
    div_cnt_d = div_cnt_q;
    qh_d      = qh_q;
    qv_d      = qv_q;
    if (tick_s) begin
      div_cnt_d = DIV_ZERO;
      if (eol_s) begin
        qh_d = 10'd0;
        if (qv_q == V_END) begin
          qv_d = 10'd0;
        end else begin
          qv_d = qv_q + 10'd1;
        end
      end else begin
        qh_d = qh_q + 10'd1;
        qv_d = qv_q;
      end
    end else begin
      div_cnt_d = div_cnt_q + DIV_ONE;
      qh_d      = qh_q;
      qv_d      = qv_q;
    end
  end

  // Horizontal phase FSM, stepped by the pixel tick.
  always_comb begin
    h_state_d = h_state_q;
    if (tick_s) begin
      case (h_state_q)
        H_VISIBLE: if (qh_q == H_VIS_END)  h_state_d = H_FRONT;   else h_state_d = H_VISIBLE;
        H_FRONT:   if (qh_q == H_FP_END)   h_state_d = H_SYNCP;   else h_state_d = H_FRONT;
        H_SYNCP:   if (qh_q == H_SYNC_END) h_state_d = H_BACK;    else h_state_d = H_SYNCP;
        H_BACK:    if (qh_q == H_END)      h_state_d = H_VISIBLE; else h_state_d = H_BACK;
        default:   h_state_d = H_VISIBLE;
      endcase
    end else begin
      h_state_d = h_state_q;
    end
  end

  // Vertical phase FSM, stepped once per line.
  always_comb begin
    v_state_d = v_state_q;
    if (eol_s) begin
      case (v_state_q)
        V_VISIBLE: if (qv_q == V_VIS_END)  v_state_d = V_FRONT;   else v_state_d = V_VISIBLE;
        V_FRONT:   if (qv_q == V_FP_END)   v_state_d = V_SYNCP;   else v_state_d = V_FRONT;
        V_SYNCP:   if (qv_q == V_SYNC_END) v_state_d = V_BACK;    else v_state_d = V_SYNCP;
        V_BACK:    if (qv_q == V_END)      v_state_d = V_VISIBLE; else v_state_d = V_BACK;
        default:   v_state_d = V_VISIBLE;
      endcase
    end else begin
      v_state_d = v_state_q;
    end
  end

  // Decode from next-state values so the flags land on the same edge as Qh/Qv.
  always_comb begin
    pixel_tick_d = (div_cnt_d == DIV_LAST);
    hsync_d      = (h_state_d != H_SYNCP);
    vsync_d      = (v_state_d != V_SYNCP);
    video_on_d   = (h_state_d == H_VISIBLE) && (v_state_d == V_VISIBLE);
    fin_cuadro_d = pixel_tick_d && (qh_d == H_END) && (qv_d == V_END);
  end

  // State register; reset wins over any pending tick.
  always_ff @(posedge reloj) begin
    if (!reset) begin
      div_cnt_q    <= DIV_ZERO;
      qh_q         <= 10'd0;
      qv_q         <= 10'd0;
      h_state_q    <= H_VISIBLE;
      v_state_q    <= V_VISIBLE;
      pixel_tick_q <= 1'b0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      video_on_q   <= 1'b1;
      fin_cuadro_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      qh_q         <= qh_d;
      qv_q         <= qv_d;
      h_state_q    <= h_state_d;
      v_state_q    <= v_state_d;
      pixel_tick_q <= pixel_tick_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      video_on_q   <= video_on_d;
      fin_cuadro_q <= fin_cuadro_d;
    end
  end

  assign Qh         = qh_q;
  assign Qv         = qv_q;
  assign pixel_tick = pixel_tick_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign video_on   = video_on_q;
  assign fin_cuadro = fin_cuadro_q;

endmodule
